// File: rtl/lowpass_pkg.sv
// lowpass_pkg: shared sample/accumulator types, default biquad
// coefficients (Q2.14) and the output saturation helper.
package lowpass_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic signed [31:0] acc_t;

    localparam int      COEF_FRAC = 14;

    // Butterworth low-pass, fc = 1 kHz at fs = 24 kHz
    localparam sample_t B0 = 16'sd236;
    localparam sample_t B1 = 16'sd472;
    localparam sample_t B2 = 16'sd236;
    localparam sample_t A1 = -16'sd26755;
    localparam sample_t A2 = 16'sd11315;

    function automatic sample_t sat16(acc_t v);
        if (v > acc_t'(32767)) begin
            return 16'sh7fff;
        end else if (v < acc_t'(-32768)) begin
            return 16'sh8000;
        end else begin
            return sample_t'(v);
        end
    endfunction

endpackage

// File: rtl/lowpass_mac.sv
// lowpass_mac: combinational five-term biquad MAC with arithmetic
// shift and saturation. Debug taps exist only with LOWPASS_DEBUG_EN.
module lowpass_mac #(
    parameter int                 COEF_FRAC = lowpass_pkg::COEF_FRAC,
    parameter lowpass_pkg::sample_t B0 = lowpass_pkg::B0,
    parameter lowpass_pkg::sample_t B1 = lowpass_pkg::B1,
    parameter lowpass_pkg::sample_t B2 = lowpass_pkg::B2,
    parameter lowpass_pkg::sample_t A1 = lowpass_pkg::A1,
    parameter lowpass_pkg::sample_t A2 = lowpass_pkg::A2
) (
    input  logic signed [15:0] x,
    input  logic signed [15:0] x1,
    input  logic signed [15:0] x2,
    input  logic signed [15:0] y1,
    input  logic signed [15:0] y2,
`ifdef LOWPASS_DEBUG_EN
    output logic signed [31:0] acc_o,
    output logic signed [31:0] fb_o,
`endif
    output logic signed [15:0] y
);
    import lowpass_pkg::*;

    acc_t ff;
    acc_t fb;
    acc_t acc;
    acc_t shifted;

    // Feed-forward minus feedback, then floor-shift and clamp
    always_comb begin
        ff = acc_t'(x)  * acc_t'(B0)
           + acc_t'(x1) * acc_t'(B1)
           + acc_t'(x2) * acc_t'(B2);
        fb = acc_t'(y1) * acc_t'(A1)
           + acc_t'(y2) * acc_t'(A2);
        acc     = ff - fb;
        shifted = acc >>> COEF_FRAC;
        y       = sat16(shifted);
    end

`ifdef LOWPASS_DEBUG_EN
    assign acc_o = acc;
    assign fb_o  = fb;
`endif

endmodule

// File: rtl/lowpass_filter.sv
// lowpass_filter: direct-form-I biquad, one sample per clock.
// Debug ports 2/3/4 are live only when LOWPASS_DEBUG_EN is defined.
module lowpass_filter #(
    parameter int                 COEF_FRAC = lowpass_pkg::COEF_FRAC,
    parameter logic signed [15:0] B0 = lowpass_pkg::B0,
    parameter logic signed [15:0] B1 = lowpass_pkg::B1,
    parameter logic signed [15:0] B2 = lowpass_pkg::B2,
    parameter logic signed [15:0] A1 = lowpass_pkg::A1,
    parameter logic signed [15:0] A2 = lowpass_pkg::A2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic signed [15:0] lowpassIn,
    output logic signed [15:0] lowpassOut,
    output logic signed [31:0] lowpassOut2,
    output logic signed [15:0] lowpassOut3,
    output logic signed [31:0] lowpassOut4
);
    import lowpass_pkg::*;

    sample_t x_in;
    sample_t y_mac;
    sample_t x1_d, x1_q;
    sample_t x2_d, x2_q;
    sample_t y1_d, y1_q;
    sample_t y2_d, y2_q;

    // Input gated in reset so the combinational taps read zero
    always_comb begin
        x_in = reset_n ? lowpassIn : '0;
    end

`ifdef LOWPASS_DEBUG_EN
    acc_t acc_dbg;
    acc_t fb_dbg;
`endif

    lowpass_mac #(
        .COEF_FRAC (COEF_FRAC),
        .B0        (B0),
        .B1        (B1),
        .B2        (B2),
        .A1        (A1),
        .A2        (A2)
    ) u_mac (
        .x     (x_in),
        .x1    (x1_q),
        .x2    (x2_q),
        .y1    (y1_q),
        .y2    (y2_q),
`ifdef LOWPASS_DEBUG_EN
        .acc_o (acc_dbg),
        .fb_o  (fb_dbg),
`endif
        .y     (y_mac)
    );

    // Shift the input and output delay lines by one sample
    always_comb begin
        x1_d = x_in;
        x2_d = x1_q;
        y1_d = y_mac;
        y2_d = y1_q;
    end

    // Delay-line state; y1 doubles as the registered output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x1_q <= '0;
            x2_q <= '0;
            y1_q <= '0;
            y2_q <= '0;
        end else begin
            x1_q <= x1_d;
            x2_q <= x2_d;
            y1_q <= y1_d;
            y2_q <= y2_d;
        end
    end

    assign lowpassOut = y1_q;

`ifdef LOWPASS_DEBUG_EN
    assign lowpassOut2 = acc_dbg;
    assign lowpassOut3 = x1_q;
    assign lowpassOut4 = fb_dbg;
`else
    assign lowpassOut2 = '0;
    assign lowpassOut3 = '0;
    assign lowpassOut4 = '0;
`endif

endmodule

// File: tb/tb_lowpass_filter.sv
// tb_lowpass_filter: vector table, directed sequences and random
// stimulus against a difference-equation reference model.
module tb_lowpass_filter;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic signed [15:0] lowpassIn = '0;
    logic signed [15:0] lowpassOut;
    logic signed [31:0] lowpassOut2;
    logic signed [15:0] lowpassOut3;
    logic signed [31:0] lowpassOut4;

    int total = 0;
    int bad   = 0;

    lowpass_filter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .lowpassIn   (lowpassIn),
        .lowpassOut  (lowpassOut),
        .lowpassOut2 (lowpassOut2),
        .lowpassOut3 (lowpassOut3),
        .lowpassOut4 (lowpassOut4)
    );

    always #5 clk = ~clk;

    // numerator b[k], denominator a[k] (a[0] = 1.0 in Q2.14)
    longint bc [3] = '{236, 472, 236};
    longint ac [3] = '{16384, -26755, 11315};
    int     xh [$];
    int     yh [$];

    int sine [16] = '{0, 6270, 11585, 15136, 16383, 15136, 11585, 6270,
                      0, -6270, -11585, -15136, -16383, -15136, -11585,
                      -6270};

    typedef struct {
        bit rst;
        int in;
        int exp;
    } vec_t;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        xh = '{0, 0};
        yh = '{0, 0};
    endfunction

    task automatic model_eval(input int in, output longint acc,
                              output longint fb, output int y);
        longint q;
        fb  = 0;
        acc = bc[0] * longint'(in);
        for (int k = 1; k <= 2; k++) begin
            acc += bc[k] * longint'(xh[k-1]);
            fb  += ac[k] * longint'(yh[k-1]);
        end
        acc -= fb;
        q = acc / 16384;
        if ((acc % 16384) != 0 && acc < 0) q -= 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        y = int'(q);
    endtask

    // called just after a falling edge; returns just after the next one
    task automatic cycle(input int in, output int y);
        longint acc, fb;
        int     ys;
        lowpassIn = 16'(in);
        model_eval(in, acc, fb, ys);
        #1;
`ifdef LOWPASS_DEBUG_EN
        chk("dbg_acc", lowpassOut2, acc);
        chk("dbg_fb", lowpassOut4, fb);
        chk("dbg_x1", lowpassOut3, xh[0]);
`else
        chk("dbg2_tied", lowpassOut2, 0);
        chk("dbg3_tied", lowpassOut3, 0);
        chk("dbg4_tied", lowpassOut4, 0);
`endif
        @(posedge clk);
        #1;
        chk("out", lowpassOut, ys);
        xh.push_front(in);
        void'(xh.pop_back());
        yh.push_front(ys);
        void'(yh.pop_back());
        y = int'(lowpassOut);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        lowpassIn = 16'sh7fff;
        #1;
        chk("rst_out", lowpassOut, 0);
        chk("rst_dbg2", lowpassOut2, 0);
        chk("rst_dbg3", lowpassOut3, 0);
        chk("rst_dbg4", lowpassOut4, 0);
        @(posedge clk);
        #1;
        chk("rst_hold_out", lowpassOut, 0);
        chk("rst_hold_dbg2", lowpassOut2, 0);
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
    endtask

    initial begin
        vec_t tbl [$];
        int   y;
        int   first [37];
        int   neg_cnt;
        int   peak;
        int   per_bad;
        int   hist [400];

        model_reset();
        tbl = '{
            '{1'b1, 32767, 471},
            '{1'b0, 32767, 2185},
            '{1'b0, 32767, 5130},
            '{1'b1, 16384, 236},
            '{1'b0, 0, 857},
            '{1'b0, 0, 1472},
            '{1'b1, -1, -1},
            '{1'b0, 0, -2},
            '{1'b1, -32768, -472}
        };

        @(negedge clk);
        do_reset();
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            cycle(tbl[i].in, y);
            chk($sformatf("vec%0d", i), y, tbl[i].exp);
        end

        // positive full-scale step
        do_reset();
        neg_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            cycle(32767, y);
            if (y < 0) neg_cnt++;
        end
        chk("step_pos_nowrap", neg_cnt, 0);
        chk("step_pos_final", (y >= 32750 && y <= 32767) ? 1 : 0, 1);

        // negative full-scale step
        do_reset();
        for (int i = 0; i < 300; i++) cycle(-32768, y);
        chk("step_neg_final", (y >= -32768 && y <= -32750) ? 1 : 0, 1);

        // impulse
        do_reset();
        cycle(16384, y);
        chk("imp_first", y, 236);
        for (int i = 0; i < 100; i++) cycle(0, y);
        chk("imp_decay", (y >= -17 && y <= 17) ? 1 : 0, 1);

        // 1.5 kHz sine
        do_reset();
        peak = 0;
        per_bad = 0;
        for (int i = 0; i < 400; i++) begin
            cycle(sine[i % 16], hist[i]);
            if (i >= 200 && hist[i] > peak) peak = hist[i];
            if (i >= 300 && (hist[i] - hist[i-16] > 3 ||
                             hist[i-16] - hist[i] > 3)) per_bad++;
        end
        chk("sine_peak", (peak >= 6000 && peak <= 7100) ? 1 : 0, 1);
        chk("sine_period", per_bad, 0);

        // reset mid-sine, then replay from fresh state
        do_reset();
        for (int i = 0; i < 37; i++) cycle(sine[i % 16], first[i]);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_out", lowpassOut, 0);
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 37; i++) begin
            cycle(sine[i % 16], y);
            chk("rerun", y, first[i]);
        end

        // random full-range samples
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cycle(int'($signed(16'($urandom))), y);
        end
        // random rail-to-rail samples to exercise clamping
        for (int i = 0; i < 200; i++) begin
            cycle($urandom_range(0, 1) ? 32767 : -32768, y);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
